// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths:
// FSM state encoding, data width and the clocks-per-bit helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Integer division on purpose: no fractional baud correction anywhere.
  function automatic int bit_time(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Processor-side handshake of the UART transmitter: byte/load in,
// serial line and ready/done status out.
interface uart_tx_if;
  logic [7:0] data;
  logic       load;
  logic       tx;
  logic       tx_ready;
  logic       tx_done;

  modport master (output data, load, input tx, tx_ready, tx_done);
  modport slave  (input data, load, output tx, tx_ready, tx_done);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BIT_TIME-1 and flags the terminal count.
// clear holds it at zero so a frame always starts on a full bit period.
module uart_baud_gen #(
  parameter int BIT_TIME = 868
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_TIME - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; defining UART_TX_PARITY_EN inserts an
// even-parity bit after the data bits (8E1).
//
// state  | meaning
// IDLE   | line high, tx_ready=1, waiting for load
// START  | start bit (tx=0) for one bit time
// DATA   | data bits LSB-first, bit_idx 0..7
// PARITY | even-parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (tx=1); tx_done pulses on its terminal count
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input logic     clock,
  input logic     reset,
  uart_tx_if.slave bus
);

  localparam int BIT_TIME = bit_time(CLK_FREQ, BAUD);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif
  logic        baud_clr;
  logic        baud_tick;

  uart_baud_gen #(.BIT_TIME(BIT_TIME)) u_baud (
    .clock (clock),
    .reset (reset),
    .clear (baud_clr),
    .tick  (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    baud_clr  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_clr = 1'b1;
        if (bus.load && ready_q) begin
          shift_d   = bus.data;
          bit_idx_d = 3'd0;
          state_d   = START;
          ready_d   = 1'b0;
          tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^bus.data;
`endif
        end
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        tx_d     = 1'b1;
        baud_clr = 1'b1;
      end
    endcase
  end

  // Reset wins over a coincident load and aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at BIT_TIME=16: stimulus pushes expected
// line frames, a line monitor decodes each frame and compares on tx_done.
module tb_uart_tx;

  localparam int BT = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * BT;

  typedef struct {
    logic [10:0] frame;
    bit          b2b;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  uart_tx_if u_if ();

  uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_frames = 0;
  int   spurious_done = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- line monitor ----------------
  logic       samples [0:FRAME_CYC-1];
  bit         in_frame = 0;
  int         cnt = 0;
  int         ncyc = 0;
  int         last_end = -100;
  int         fall_gap = 0;
  int         ready_bad = 0;
  int         done_early = 0;

  task automatic finish_frame();
    logic [10:0] got;
    int          glitches;
    exp_t        e;
    got = '0;
    glitches = 0;
    for (int b = 0; b < FRAME_BITS; b++) got[b] = samples[b*BT + BT/2];
    for (int i = 0; i < FRAME_CYC; i++)
      if (samples[i] !== samples[(i/BT)*BT + BT/2]) glitches++;
    n_frames++;
    if (sb_q.size() == 0) begin
      check("unexpected_frame", got, 0);
    end else begin
      e = sb_q.pop_front();
      check("frame_bits", got, e.frame);
      check("bit_width", glitches, 0);
      check("ready_low", ready_bad, 0);
      check("done_early", done_early, 0);
      check("done_pulse", u_if.tx_done, 1);
      check("ready_back", u_if.tx_ready, 1);
      if (e.b2b) check("b2b_gap", fall_gap, 1);
    end
  endtask

  always @(negedge clock) begin
    ncyc++;
    if (reset) begin
      in_frame = 0;
    end else if (!in_frame) begin
      if (u_if.tx_done === 1'b1) spurious_done++;
      if (u_if.tx === 1'b0) begin
        in_frame   = 1;
        cnt        = 0;
        fall_gap   = ncyc - last_end;
        samples[0] = u_if.tx;
        ready_bad  = (u_if.tx_ready !== 1'b0) ? 1 : 0;
        done_early = 0;
      end
    end else begin
      cnt++;
      if (cnt < FRAME_CYC) begin
        samples[cnt] = u_if.tx;
        if (u_if.tx_ready !== 1'b0) ready_bad++;
        if (u_if.tx_done !== 1'b0) done_early++;
      end else begin
        finish_frame();
        in_frame = 0;
        last_end = ncyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [10:0] f_8n1,
                      input logic [10:0] f_8e1, input bit b2b);
    exp_t e;
`ifdef UART_TX_PARITY_EN
    e.frame = f_8e1;
`else
    e.frame = f_8n1;
`endif
    e.b2b = b2b;
    sb_q.push_back(e);
    n_pushed++;
    u_if.data = d;
    u_if.load = 1'b1;
    step();
    u_if.load = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (u_if.tx_done === 1'b1) seen = 1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    int line_low;
    reset     = 1'b1;
    u_if.load = 1'b0;
    u_if.data = 8'h00;

    // reset held for 3 cycles, then released
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx", u_if.tx, 1);
      check("rst_ready", u_if.tx_ready, 1);
      check("rst_done", u_if.tx_done, 0);
    end
    reset = 1'b0;
    step();
    check("post_rst_tx", u_if.tx, 1);
    check("post_rst_ready", u_if.tx_ready, 1);
    check("post_rst_done", u_if.tx_done, 0);

    // single frame 0x55
    send(8'h55, 11'h2AA, 11'h4AA, 0);
    check("start_latency", u_if.tx, 0);
    wait_done();
    repeat (3) step();

    // load while busy is ignored; then back-to-back load in the done cycle
    send(8'h0F, 11'h21E, 11'h41E, 0);
    repeat (40) step();
    check("busy_ready", u_if.tx_ready, 0);
    u_if.data = 8'hA3;
    u_if.load = 1'b1;
    step();
    u_if.load = 1'b0;
    wait_done();
    send(8'hA3, 11'h346, 11'h546, 1);
    wait_done();
    repeat (3) step();

    // reset around cycle 70 of a 0xFF frame aborts it
    u_if.data = 8'hFF;
    u_if.load = 1'b1;
    step();
    u_if.load = 1'b0;
    check("abort_started", u_if.tx, 0);
    repeat (69) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_tx", u_if.tx, 1);
    check("abort_ready", u_if.tx_ready, 1);
    check("abort_done", u_if.tx_done, 0);
    repeat (2) step();

    send(8'h00, 11'h200, 11'h400, 0);
    wait_done();
    repeat (3) step();

`ifdef UART_TX_PARITY_EN
    send(8'h07, 11'h20E, 11'h60E, 0);
    wait_done();
    repeat (3) step();
    send(8'h03, 11'h206, 11'h406, 0);
    wait_done();
    repeat (3) step();
`endif

    // reset and load together: reset wins
    reset     = 1'b1;
    u_if.data = 8'h81;
    u_if.load = 1'b1;
    step();
    reset     = 1'b0;
    u_if.load = 1'b0;
    check("rl_tx", u_if.tx, 1);
    check("rl_ready", u_if.tx_ready, 1);
    line_low = 0;
    for (int i = 0; i < 2*BT; i++) begin
      step();
      if (u_if.tx !== 1'b1) line_low++;
    end
    check("rl_line_idle", line_low, 0);

    repeat (5) step();
    check("sb_empty", sb_q.size(), 0);
    check("frame_count", n_frames, n_pushed);
    check("spurious_done", spurious_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, 8N1 framing; the outbound counterpart to the receive/display path.
- Accepts a byte from the TramelBlaze output port via a one-cycle load strobe.
- Shifts the byte out LSB-first at a fixed baud rate on a single line.
- Reports idle/busy and end-of-frame back to the processor for polling or interrupt.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bits/s.
- BIT_TIME, CLK_FREQ/BAUD (integer division, 868 at defaults): clock cycles per bit. Derived; do not override.

Ports:
- clock, input, 1: system clock. All logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- data, input, 8: byte to transmit. Sampled only on an accepted load.
- load, input, 1: one-cycle strobe requesting transmission of data.
- tx, output, 1: serial line. Idles high.
- tx_ready, output, 1: high when a load will be accepted.
- tx_done, output, 1: one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (sampled on a clock edge):
  - tx=1, tx_ready=1, tx_done=0.
  - State IDLE; bit counter 0; baud counter 0; shift register 0x00.
  - A reset mid-frame aborts the frame: tx=1 on the next edge, and the partial frame is never completed.
- States: IDLE -> START -> DATA -> STOP -> IDLE. PARITY sits between DATA and STOP only when the optional feature is enabled.
- Load acceptance:
  - A load is accepted only when tx_ready=1.
  - On the accepting edge: data is latched into the shift register, state goes to START, tx_ready=0, baud counter=0.
  - tx goes low on the cycle following the load (latency of 1 cycle).
  - A load while tx_ready=0 is ignored, and data is not sampled.
- Bit timing:
  - Each line bit is held for exactly BIT_TIME cycles.
  - The baud counter counts 0..BIT_TIME-1 and wraps to 0 at the terminal count. The state or bit advances on the terminal count.
  - There is no fractional baud correction.
- START: tx=0 for one bit time, then DATA with bit index 0.
- DATA:
  - tx = shift_reg[0]; the register shifts right at each terminal count.
  - The 3-bit index counts 0..7. After bit 7, go to STOP (or PARITY when enabled).
- STOP: tx=1 for one bit time.
- End of frame (on the STOP terminal-count edge):
  - tx_done=1 for exactly one cycle.
  - tx_ready returns to 1 and the state returns to IDLE.
- Frame length: 10*BIT_TIME cycles from tx falling to tx_done (11*BIT_TIME with parity).
- Back-to-back loads:
  - A load asserted in the same cycle tx_done is high is accepted, since tx_ready is already 1.
  - The next start bit then begins with no idle gap beyond the 1-cycle load latency.
- Simultaneous reset and load: reset wins, and the load is dropped.
- tx is registered, so no combinational glitches reach the pin.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is inserted after bit 7. It drives the even-parity bit (XOR of the 8 latched data bits) for one bit time.
  - The frame becomes 11 bits (8E1).
- Undefined:
  - No PARITY state and no parity logic; 8N1 only.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit wide;
  - DATA_BITS=8;
  - a bit_time(clk_freq, baud) constant function, also used by the receive side.
- One natural sub-module, uart_baud_gen:
  - a counter parameterised by BIT_TIME with a clear input and a terminal-count tick output;
  - reusable by the receiver.
- uart_tx keeps the FSM, shift register and bit index.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD=1, so BIT_TIME=16.
1. Hold reset high for 3 cycles -> tx=1, tx_ready=1, tx_done=0 throughout and after release.
2. load with data=0x55 -> tx low 1 cycle later for 16 cycles, then 1,0,1,0,1,0,1,0, then high. tx_done pulses exactly 160 cycles after tx falls; tx_ready=0 for those 160 cycles.
3. load 0xA3 while busy sending 0x0F -> 0x0F completes intact and 0xA3 never appears on tx. Then load 0xA3 in the tx_done cycle -> next start bit follows with a 1-cycle gap, and the bits 1,1,0,0,0,1,0,1 are decoded.
4. Assert reset at cycle 70 of a 0xFF frame -> tx=1 next edge and tx_ready=1. No tx_done occurs, and a subsequent load 0x00 transmits a correct frame.
5. With UART_TX_PARITY_EN defined:
   - data 0x07 -> parity bit 1 and frame length 176 cycles;
   - data 0x03 -> parity bit 0.
6. Simultaneous reset and load 0x81 -> no start bit, tx stays 1, tx_ready=1.
